// File: rtl/sfu_check_multi_if.sv
// Beat bus for the SFU conflict checker: input/output
// streams, mode select, counter clear and conflict count.
interface sfu_check_multi_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int LABEL_WIDTH = 4,
  parameter int NUM_CH      = 4,
  parameter int CNT_WIDTH   = 16
);
  logic                          mode;
  logic                          x_valid;
  logic                          x_ready;
  logic [NUM_CH*DATA_WIDTH-1:0]  x_data;
  logic [NUM_CH*LABEL_WIDTH-1:0] x_label;
  logic                          y_valid;
  logic                          y_ready;
  logic [NUM_CH*DATA_WIDTH-1:0]  y_data;
  logic [NUM_CH*LABEL_WIDTH-1:0] y_label;
  logic [NUM_CH-1:0]             y_keep;
  logic                          flag_same_sfu;
  logic                          cnt_clr;
  logic [CNT_WIDTH-1:0]          conflict_cnt;

  modport slave (
    input  mode, x_valid, x_data, x_label,
    input  y_ready, cnt_clr,
    output x_ready, y_valid, y_data, y_label,
    output y_keep, flag_same_sfu, conflict_cnt
  );

  modport master (
    output mode, x_valid, x_data, x_label,
    output y_ready, cnt_clr,
    input  x_ready, y_valid, y_data, y_label,
    input  y_keep, flag_same_sfu, conflict_cnt
  );
endinterface

// File: rtl/sfu_check_multi.sv
// Two-stage SFU conflict checker: masks channels whose
// antennas share an SFU and counts conflicting beats.
module sfu_check_multi #(
  parameter int DATA_WIDTH    = 8,
  parameter int LABEL_WIDTH   = 4,
  parameter int NUM_CH        = 4,
  parameter int SFU_SIZE_LOG2 = 1,
  parameter int CNT_WIDTH     = 16
) (
  input logic               clk,
  input logic               rst,
  sfu_check_multi_if.slave  bus
);

  localparam int DW = NUM_CH * DATA_WIDTH;
  localparam int LW = NUM_CH * LABEL_WIDTH;
  localparam int MW = NUM_CH * NUM_CH;

  logic          advance;

  logic          v1_q, v1_d;
  logic [DW-1:0] d1_q, d1_d;
  logic [LW-1:0] l1_q, l1_d;
  logic          m1_q, m1_d;
  logic [MW-1:0] mt_q, mt_d;

  logic              yv_q, yv_d;
  logic [DW-1:0]     yd_q, yd_d;
  logic [LW-1:0]     yl_q, yl_d;
  logic [NUM_CH-1:0] yk_q, yk_d;
  logic              fl_q, fl_d;

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [MW-1:0]     match;
  logic [NUM_CH-1:0] keep;
  logic              any_c;
  logic [DW-1:0]     masked;

  assign advance           = bus.y_ready | ~yv_q;
  assign bus.x_ready       = advance;
  assign bus.y_valid       = yv_q;
  assign bus.y_data        = yd_q;
  assign bus.y_label       = yl_q;
  assign bus.y_keep        = yk_q;
  assign bus.flag_same_sfu = fl_q;
  assign bus.conflict_cnt  = cnt_q;

  // match[i*NUM_CH+j]: channels i and j map to the same SFU
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      for (int j = 0; j < NUM_CH; j++) begin
        if (i != j) begin
          match[i*NUM_CH+j] =
            (bus.x_label[i*LABEL_WIDTH +: LABEL_WIDTH]
              >> SFU_SIZE_LOG2) ==
            (bus.x_label[j*LABEL_WIDTH +: LABEL_WIDTH]
              >> SFU_SIZE_LOG2);
        end
      end
    end
  end

  always_comb begin
    keep   = '1;
    any_c  = 1'b0;
    masked = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      for (int j = 0; j < NUM_CH; j++) begin
        if (mt_q[i*NUM_CH+j]) begin
          any_c = 1'b1;
          if (!m1_q || j < i) begin
            keep[i] = 1'b0;
          end
        end
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (keep[i]) begin
        masked[i*DATA_WIDTH +: DATA_WIDTH] =
          d1_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    v1_d = v1_q;
    d1_d = d1_q;
    l1_d = l1_q;
    m1_d = m1_q;
    mt_d = mt_q;
    yv_d = yv_q;
    yd_d = yd_q;
    yl_d = yl_q;
    yk_d = yk_q;
    fl_d = fl_q;
    if (advance) begin
      v1_d = bus.x_valid;
      if (bus.x_valid) begin
        d1_d = bus.x_data;
        l1_d = bus.x_label;
        m1_d = bus.mode;
        mt_d = match;
      end
      yv_d = v1_q;
      if (v1_q) begin
        yd_d = masked;
        yl_d = l1_q;
        yk_d = keep;
        fl_d = any_c;
      end
    end
  end

  // clear wins over a same-cycle increment
  always_comb begin
    cnt_d = cnt_q;
    if (bus.cnt_clr) begin
      cnt_d = '0;
    end else if (yv_q && bus.y_ready && fl_q && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q  <= 1'b0;
      d1_q  <= '0;
      l1_q  <= '0;
      m1_q  <= 1'b0;
      mt_q  <= '0;
      yv_q  <= 1'b0;
      yd_q  <= '0;
      yl_q  <= '0;
      yk_q  <= '0;
      fl_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      v1_q  <= v1_d;
      d1_q  <= d1_d;
      l1_q  <= l1_d;
      m1_q  <= m1_d;
      mt_q  <= mt_d;
      yv_q  <= yv_d;
      yd_q  <= yd_d;
      yl_q  <= yl_d;
      yk_q  <= yk_d;
      fl_q  <= fl_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sfu_check_multi.sv
// Bench for sfu_check_multi: directed vectors plus a
// randomized run against a queue-based reference model.
module tb_sfu_check_multi;

  localparam int DW = 8;
  localparam int LW = 4;
  localparam int N  = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sfu_check_multi_if #(
    .DATA_WIDTH(DW), .LABEL_WIDTH(LW),
    .NUM_CH(N), .CNT_WIDTH(16)
  ) bm ();

  sfu_check_multi_if #(
    .DATA_WIDTH(DW), .LABEL_WIDTH(LW),
    .NUM_CH(N), .CNT_WIDTH(2)
  ) bs ();

  assign bs.mode    = bm.mode;
  assign bs.x_valid = bm.x_valid;
  assign bs.x_data  = bm.x_data;
  assign bs.x_label = bm.x_label;
  assign bs.y_ready = bm.y_ready;
  assign bs.cnt_clr = bm.cnt_clr;

  sfu_check_multi #(
    .DATA_WIDTH(DW), .LABEL_WIDTH(LW), .NUM_CH(N),
    .SFU_SIZE_LOG2(1), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .bus(bm)
  );

  sfu_check_multi #(
    .DATA_WIDTH(DW), .LABEL_WIDTH(LW), .NUM_CH(N),
    .SFU_SIZE_LOG2(1), .CNT_WIDTH(2)
  ) dut_s (
    .clk(clk), .rst(rst), .bus(bs)
  );

  typedef struct {
    logic [N*DW-1:0] d;
    logic [N*LW-1:0] l;
    logic [N-1:0]    k;
    logic            f;
  } exp_t;

  int checks = 0;
  int errors = 0;
  int cnt_exp = 0;

  function automatic logic [N*DW-1:0] pk_d(
    input int a, input int b, input int c, input int e);
    return {8'(e), 8'(c), 8'(b), 8'(a)};
  endfunction

  function automatic logic [N*LW-1:0] pk_l(
    input int a, input int b, input int c, input int e);
    return {4'(e), 4'(c), 4'(b), 4'(a)};
  endfunction

  function automatic int sat_of(input int c);
    return (c > 3) ? 3 : c;
  endfunction

  // Reference: SFU id = label / 2 (two antennas per SFU)
  function automatic exp_t model(
    input logic [N*LW-1:0] lab,
    input logic [N*DW-1:0] dat,
    input logic            md);
    exp_t e;
    int   sfu [N];
    for (int i = 0; i < N; i++)
      sfu[i] = int'(lab[i*LW +: LW]) / 2;
    e.l = lab;
    e.f = 1'b0;
    e.d = '0;
    for (int i = 0; i < N; i++) begin
      e.k[i] = 1'b1;
      for (int j = 0; j < N; j++) begin
        if (j != i && sfu[i] == sfu[j]) begin
          e.f = 1'b1;
          if (!md || j < i) e.k[i] = 1'b0;
        end
      end
      if (e.k[i]) e.d[i*DW +: DW] = dat[i*DW +: DW];
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bm.mode = 1'b0;
    bm.x_valid = 1'b0;
    bm.x_data = '0;
    bm.x_label = '0;
    bm.y_ready = 1'b1;
    bm.cnt_clr = 1'b0;
    #3;
    checks++;
    if (bm.y_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_y_valid: got %b exp 0", bm.y_valid);
    end
    checks++;
    if (bm.x_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_x_ready: got %b exp 1", bm.x_ready);
    end
    checks++;
    if (bm.y_data !== '0 || bm.y_label !== '0 ||
        bm.y_keep !== '0 || bm.flag_same_sfu !== 1'b0) begin
      errors++;
      $display("FAIL rst_outputs: got %h %h %b %b exp 0",
        bm.y_data, bm.y_label, bm.y_keep, bm.flag_same_sfu);
    end
    checks++;
    if (bm.conflict_cnt !== 16'd0 || bs.conflict_cnt !== 2'd0) begin
      errors++;
      $display("FAIL rst_cnt: got %0d/%0d exp 0",
        bm.conflict_cnt, bs.conflict_cnt);
    end
    tick();
    tick();
    rst = 1'b1;
    cnt_exp = 0;
    #1;
    checks++;
    if (bm.x_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_rst_x_ready: got %b exp 1", bm.x_ready);
    end
  endtask

  task automatic test_no_conflict();
    bm.x_label = pk_l(0, 2, 4, 6);
    bm.x_data = pk_d(11, 22, 33, 44);
    bm.mode = 1'b0;
    bm.y_ready = 1'b1;
    bm.x_valid = 1'b1;
    tick();
    bm.x_valid = 1'b0;
    checks++;
    if (bm.y_valid !== 1'b0) begin
      errors++;
      $display("FAIL lat_early: got y_valid %b exp 0", bm.y_valid);
    end
    tick();
    checks++;
    if (bm.y_valid !== 1'b1) begin
      errors++;
      $display("FAIL lat_2: got y_valid %b exp 1", bm.y_valid);
    end
    checks++;
    if (bm.y_data !== pk_d(11, 22, 33, 44) || bm.y_keep !== 4'hf
        || bm.flag_same_sfu !== 1'b0
        || bm.y_label !== pk_l(0, 2, 4, 6)) begin
      errors++;
      $display("FAIL noconf_beat: got %h %b %b %h exp %h 1111 0 %h",
        bm.y_data, bm.y_keep, bm.flag_same_sfu, bm.y_label,
        pk_d(11, 22, 33, 44), pk_l(0, 2, 4, 6));
    end
    tick();
    checks++;
    if (bm.y_valid !== 1'b0 || bm.conflict_cnt !== 16'(cnt_exp)) begin
      errors++;
      $display("FAIL noconf_after: got v=%b cnt=%0d exp v=0 cnt=%0d",
        bm.y_valid, bm.conflict_cnt, cnt_exp);
    end
  endtask

  task automatic test_conflict_modes();
    bm.x_label = pk_l(0, 1, 4, 5);
    bm.x_data = pk_d(11, 22, 33, 44);
    bm.y_ready = 1'b1;
    bm.x_valid = 1'b1;
    bm.mode = 1'b0;
    tick();
    bm.mode = 1'b1;
    tick();
    bm.x_valid = 1'b0;
    bm.mode = 1'b0;
    checks++;
    if (bm.y_valid !== 1'b1 || bm.y_data !== '0 ||
        bm.y_keep !== 4'b0000 || bm.flag_same_sfu !== 1'b1) begin
      errors++;
      $display("FAIL mode0_beat: got v=%b %h %b f=%b exp 1 0 0000 1",
        bm.y_valid, bm.y_data, bm.y_keep, bm.flag_same_sfu);
    end
    tick();
    cnt_exp++;
    checks++;
    if (bm.conflict_cnt !== 16'(cnt_exp)) begin
      errors++;
      $display("FAIL mode0_cnt: got %0d exp %0d",
        bm.conflict_cnt, cnt_exp);
    end
    checks++;
    if (bm.y_valid !== 1'b1 || bm.y_data !== pk_d(11, 0, 33, 0) ||
        bm.y_keep !== 4'b0101 || bm.flag_same_sfu !== 1'b1) begin
      errors++;
      $display("FAIL mode1_beat: got v=%b %h %b f=%b exp 1 %h 0101 1",
        bm.y_valid, bm.y_data, bm.y_keep, bm.flag_same_sfu,
        pk_d(11, 0, 33, 0));
    end
    tick();
    cnt_exp++;
    checks++;
    if (bm.conflict_cnt !== 16'(cnt_exp) ||
        bs.conflict_cnt !== 2'(sat_of(cnt_exp))) begin
      errors++;
      $display("FAIL mode1_cnt: got %0d/%0d exp %0d/%0d",
        bm.conflict_cnt, bs.conflict_cnt, cnt_exp, sat_of(cnt_exp));
    end
  endtask

  task automatic test_label_cases();
    logic [N*DW-1:0] d0, d1;
    exp_t e0, e1;
    d0 = {$urandom, $urandom} >> 32;
    d1 = {$urandom, $urandom} >> 32;
    e0 = model(pk_l(3, 3, 8, 12), d0, 1'b1);
    e1 = model(pk_l(1, 2, 5, 6), d1, 1'b1);
    bm.mode = 1'b1;
    bm.y_ready = 1'b1;
    bm.x_valid = 1'b1;
    bm.x_label = pk_l(3, 3, 8, 12);
    bm.x_data = d0;
    tick();
    bm.x_label = pk_l(1, 2, 5, 6);
    bm.x_data = d1;
    tick();
    bm.x_valid = 1'b0;
    checks++;
    if (bm.y_keep !== 4'b1101 || bm.flag_same_sfu !== 1'b1 ||
        bm.y_data !== e0.d) begin
      errors++;
      $display("FAIL same_label: got %b f=%b %h exp 1101 1 %h",
        bm.y_keep, bm.flag_same_sfu, bm.y_data, e0.d);
    end
    tick();
    cnt_exp++;
    checks++;
    if (bm.y_keep !== 4'b1111 || bm.flag_same_sfu !== 1'b0 ||
        bm.y_data !== d1) begin
      errors++;
      $display("FAIL adj_labels: got %b f=%b %h exp 1111 0 %h",
        bm.y_keep, bm.flag_same_sfu, bm.y_data, d1);
    end
    tick();
    checks++;
    if (bm.conflict_cnt !== 16'(cnt_exp)) begin
      errors++;
      $display("FAIL label_cnt: got %0d exp %0d",
        bm.conflict_cnt, cnt_exp);
    end
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int got = 0;
    logic stalled = 1'b0;
    logic [N*DW-1:0] saved = '0;
    bm.mode = 1'b0;
    bm.x_label = pk_l(0, 2, 4, 6);
    for (int cyc = 0; cyc < 30; cyc++) begin
      bm.x_valid = (sent < 12);
      bm.x_data = pk_d(sent + 1, 8'h55, 8'haa, sent + 100);
      bm.y_ready = !(cyc >= 4 && cyc < 7);
      #1;
      if (cyc == 5 || cyc == 6) begin
        checks++;
        if (bm.x_ready !== 1'b0) begin
          errors++;
          $display("FAIL bp_x_ready: cyc %0d got %b exp 0",
            cyc, bm.x_ready);
        end
      end
      if (bm.y_valid && !bm.y_ready) begin
        if (stalled) begin
          checks++;
          if (bm.y_data !== saved || bm.y_keep !== 4'hf) begin
            errors++;
            $display("FAIL bp_stable: got %h %b exp %h 1111",
              bm.y_data, bm.y_keep, saved);
          end
        end
        saved = bm.y_data;
        stalled = 1'b1;
      end else begin
        stalled = 1'b0;
      end
      if (bm.y_valid && bm.y_ready) begin
        checks++;
        if (bm.y_data !== pk_d(got + 1, 8'h55, 8'haa, got + 100)) begin
          errors++;
          $display("FAIL bp_order: got %h exp %h", bm.y_data,
            pk_d(got + 1, 8'h55, 8'haa, got + 100));
        end
        got++;
      end
      if (bm.x_valid && bm.x_ready) sent++;
      tick();
    end
    checks++;
    if (got != 12 || bm.y_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_count: got %0d beats v=%b exp 12 v=0",
        got, bm.y_valid);
    end
    bm.x_valid = 1'b0;
  endtask

  task automatic test_saturation();
    bm.cnt_clr = 1'b1;
    bm.x_valid = 1'b0;
    bm.y_ready = 1'b1;
    tick();
    bm.cnt_clr = 1'b0;
    cnt_exp = 0;
    bm.x_label = pk_l(0, 1, 4, 5);
    bm.mode = 1'b1;
    bm.x_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bm.x_data = pk_d(i, i, i, i);
      tick();
    end
    bm.x_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    cnt_exp = 5;
    checks++;
    if (bs.conflict_cnt !== 2'd3) begin
      errors++;
      $display("FAIL sat_cnt: got %0d exp 3", bs.conflict_cnt);
    end
    checks++;
    if (bm.conflict_cnt !== 16'd5) begin
      errors++;
      $display("FAIL wide_cnt: got %0d exp 5", bm.conflict_cnt);
    end
    bm.x_valid = 1'b1;
    tick();
    bm.x_valid = 1'b0;
    tick();
    bm.cnt_clr = 1'b1;
    #1;
    checks++;
    if (bm.y_valid !== 1'b1 || bm.flag_same_sfu !== 1'b1) begin
      errors++;
      $display("FAIL clr_setup: got v=%b f=%b exp 1 1",
        bm.y_valid, bm.flag_same_sfu);
    end
    tick();
    bm.cnt_clr = 1'b0;
    cnt_exp = 0;
    checks++;
    if (bm.conflict_cnt !== 16'd0 || bs.conflict_cnt !== 2'd0) begin
      errors++;
      $display("FAIL clr_prio: got %0d/%0d exp 0",
        bm.conflict_cnt, bs.conflict_cnt);
    end
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    logic out_fire;
    logic out_flag;
    bm.cnt_clr = 1'b1;
    bm.x_valid = 1'b0;
    bm.y_ready = 1'b1;
    tick();
    tick();
    cnt_exp = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bm.x_valid = (cyc < 380) && ($urandom_range(0, 3) != 0);
      bm.y_ready = (cyc >= 380) || ($urandom_range(0, 3) != 0);
      bm.mode = 1'($urandom_range(0, 1));
      bm.x_label = 16'($urandom);
      bm.x_data = 32'($urandom);
      bm.cnt_clr = ($urandom_range(0, 49) == 0);
      #1;
      checks++;
      if (bm.x_ready !== (!bm.y_valid || bm.y_ready)) begin
        errors++;
        $display("FAIL rnd_x_ready: got %b exp %b",
          bm.x_ready, (!bm.y_valid || bm.y_ready));
      end
      out_fire = bm.y_valid && bm.y_ready;
      out_flag = 1'b0;
      if (out_fire) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rnd_extra: got unexpected beat %h exp none",
            bm.y_data);
        end else begin
          e = q.pop_front();
          out_flag = e.f;
          if (bm.y_data !== e.d || bm.y_label !== e.l ||
              bm.y_keep !== e.k || bm.flag_same_sfu !== e.f) begin
            errors++;
            $display("FAIL rnd_beat: got %h %h %b %b exp %h %h %b %b",
              bm.y_data, bm.y_label, bm.y_keep, bm.flag_same_sfu,
              e.d, e.l, e.k, e.f);
          end
        end
      end
      if (bm.x_valid && bm.x_ready)
        q.push_back(model(bm.x_label, bm.x_data, bm.mode));
      if (bm.cnt_clr) cnt_exp = 0;
      else if (out_fire && out_flag) cnt_exp++;
      tick();
      checks++;
      if (bm.conflict_cnt !== 16'(cnt_exp) ||
          bs.conflict_cnt !== 2'(sat_of(cnt_exp))) begin
        errors++;
        $display("FAIL rnd_cnt: got %0d/%0d exp %0d/%0d",
          bm.conflict_cnt, bs.conflict_cnt, cnt_exp, sat_of(cnt_exp));
      end
    end
    bm.cnt_clr = 1'b0;
    checks++;
    if (q.size() != 0 || bm.y_valid !== 1'b0) begin
      errors++;
      $display("FAIL rnd_drain: got %0d pending v=%b exp 0 v=0",
        q.size(), bm.y_valid);
    end
  endtask

  task automatic test_async_reset();
    bm.x_label = pk_l(0, 1, 2, 3);
    bm.x_data = pk_d(1, 2, 3, 4);
    bm.mode = 1'b0;
    bm.y_ready = 1'b0;
    bm.x_valid = 1'b1;
    tick();
    tick();
    bm.x_valid = 1'b0;
    checks++;
    if (bm.y_valid !== 1'b1) begin
      errors++;
      $display("FAIL ar_setup: got v=%b exp 1", bm.y_valid);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (bm.y_valid !== 1'b0 || bm.y_data !== '0 ||
        bm.y_label !== '0 || bm.y_keep !== '0 ||
        bm.flag_same_sfu !== 1'b0) begin
      errors++;
      $display("FAIL ar_outputs: got v=%b %h %h %b f=%b exp all 0",
        bm.y_valid, bm.y_data, bm.y_label, bm.y_keep,
        bm.flag_same_sfu);
    end
    checks++;
    if (bm.conflict_cnt !== 16'd0 || bm.x_ready !== 1'b1) begin
      errors++;
      $display("FAIL ar_cnt_ready: got cnt=%0d rdy=%b exp 0 1",
        bm.conflict_cnt, bm.x_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    cnt_exp = 0;
    bm.y_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bm.y_valid !== 1'b0) begin
        errors++;
        $display("FAIL ar_flush: cyc %0d got v=%b exp 0",
          i, bm.y_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_no_conflict();
    test_conflict_modes();
    test_label_cases();
    test_backpressure();
    test_saturation();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end

endmodule
